// File: rtl/usb_pkg.sv
// Shared USB token definitions: PID codes, SYNC pattern, token transmitter states.
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SETUP = 4'b1101,
        PID_SOF   = 4'b0101
    } pid_e;

    localparam logic [7:0]  SYNC_BYTE = 8'h80;
    localparam int unsigned FIELD_W   = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_WAIT_CRC,
        ST_CRC,
        ST_EOP
    } tx_state_e;

    // PID byte as it goes on the wire: check nibble above the PID nibble.
    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_token_tx_if.sv
// Token request bundle between a requester and usb_token_tx.
// Define USB_SOF_EN to add the SOF request fields (tok_sof, tok_frame).
interface usb_token_tx_if;
    logic        tok_req;
    logic [3:0]  tok_pid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic        tok_busy;
`ifdef USB_SOF_EN
    logic        tok_sof;
    logic [10:0] tok_frame;
`endif

    modport master (
        output tok_req, tok_pid, tok_addr, tok_endp,
`ifdef USB_SOF_EN
        output tok_sof, tok_frame,
`endif
        input  tok_busy
    );

    modport slave (
        input  tok_req, tok_pid, tok_addr, tok_endp,
`ifdef USB_SOF_EN
        input  tok_sof, tok_frame,
`endif
        output tok_busy
    );
endinterface

// File: rtl/piso_register.sv
// Parallel-in serial-out shift register, LSB first; load has priority over shift.
module piso_register #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (load)
            q <= din;
        else if (shift)
            q <= {1'b0, q[WIDTH-1:1]};
    end

    assign sout = q[0];
endmodule

// File: rtl/usb_token_tx.sv
// USB token packet transmitter: SYNC, PID, addr/endp (or SOF frame), CRC5 from an external engine, EOP.
// Define USB_SOF_EN to support SOF tokens carrying an 11-bit frame number.
module usb_token_tx
    import usb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    usb_token_tx_if.slave tok,
    output logic          out_bit,
    output logic          out_valid,
    output logic          out_eop,
    output logic          crc5_start,
    output logic          crc5_sin,
    output logic          crc5_rec,
    input  logic          crc5_out,
    input  logic          crc5_ready,
    input  logic          crc5_done
);
    tx_state_e          state, state_d;
    logic [3:0]         cnt, cnt_d;
    logic [3:0]         pid_q;
    logic [FIELD_W-1:0] field_q;
    logic               cap_en;
    logic               piso_load, piso_shift, piso_sout;
    logic [FIELD_W-1:0] piso_din;

    piso_register #(.WIDTH(FIELD_W)) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (piso_load),
        .shift (piso_shift),
        .din   (piso_din),
        .sout  (piso_sout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pid_q   <= '0;
            field_q <= '0;
        end else if (cap_en) begin
`ifdef USB_SOF_EN
            if (tok.tok_sof) begin
                pid_q   <= PID_SOF;
                field_q <= tok.tok_frame;
            end else begin
                pid_q   <= tok.tok_pid;
                field_q <= {tok.tok_endp, tok.tok_addr};
            end
`else
            pid_q   <= tok.tok_pid;
            field_q <= {tok.tok_endp, tok.tok_addr};
`endif
        end
    end

    assign tok.tok_busy = (state != ST_IDLE);

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        cap_en     = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_din   = '0;
        out_bit    = 1'b0;
        out_valid  = 1'b0;
        out_eop    = 1'b0;
        crc5_start = 1'b0;
        crc5_sin   = 1'b0;
        crc5_rec   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tok.tok_req) begin
                    cap_en    = 1'b1;
                    piso_load = 1'b1;
                    piso_din  = {3'b000, SYNC_BYTE};
                    cnt_d     = '0;
                    state_d   = ST_SYNC;
                end
            end
            ST_SYNC: begin
                out_valid = 1'b1;
                out_bit   = piso_sout;
                if (cnt == 4'd7) begin
                    piso_load = 1'b1;
                    piso_din  = {3'b000, pid_byte(pid_q)};
                    cnt_d     = '0;
                    state_d   = ST_PID;
                end else begin
                    piso_shift = 1'b1;
                    cnt_d      = cnt + 4'd1;
                end
            end
            ST_PID: begin
                out_valid = 1'b1;
                out_bit   = piso_sout;
                if (cnt == 4'd7) begin
                    crc5_start = 1'b1;
                    piso_load  = 1'b1;
                    piso_din   = field_q;
                    cnt_d      = '0;
                    state_d    = ST_DATA;
                end else begin
                    piso_shift = 1'b1;
                    cnt_d      = cnt + 4'd1;
                end
            end
            ST_DATA: begin
                out_valid  = 1'b1;
                out_bit    = piso_sout;
                crc5_sin   = piso_sout;
                piso_shift = 1'b1;
                if (cnt == 4'd10) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_CRC;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            // WAIT_CRC only lasts while ready is low; the first ready cycle is
            // already a CRC bit, so the engine never has to hold a bit back.
            ST_WAIT_CRC, ST_CRC: begin
                if (crc5_ready) begin
                    out_valid = 1'b1;
                    out_bit   = crc5_out;
                    if (cnt == 4'd4) begin
                        cnt_d   = '0;
                        state_d = ST_EOP;
                    end else begin
                        cnt_d   = cnt + 4'd1;
                        state_d = ST_CRC;
                    end
                end
            end
            ST_EOP: begin
                if (crc5_done) begin
                    out_eop  = 1'b1;
                    crc5_rec = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_usb_token_tx.sv
// Self-checking bench for usb_token_tx with a behavioural CRC5 engine stub and a packet-level wire model.
module tb_usb_token_tx;
    import usb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic out_bit, out_valid, out_eop, crc5_start, crc5_sin, crc5_rec;
    logic crc5_out, crc5_ready, crc5_done;

    usb_token_tx_if tok_if();

    usb_token_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tok        (tok_if),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .out_eop    (out_eop),
        .crc5_start (crc5_start),
        .crc5_sin   (crc5_sin),
        .crc5_rec   (crc5_rec),
        .crc5_out   (crc5_out),
        .crc5_ready (crc5_ready),
        .crc5_done  (crc5_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wire model: whole packet in time order, first bit at [31].
    function automatic logic [31:0] build_pkt(input logic [3:0] pid, input logic [10:0] field);
        logic [31:0] v;
        logic [7:0]  sb, pb;
        logic [4:0]  c;
        sb = 8'h80;
        pb = {~pid, pid};
        for (int t = 0; t < 8; t++) begin
            v[31-t] = sb[t];
            v[23-t] = pb[t];
        end
        c = 5'h1F;
        for (int t = 0; t < 11; t++) begin
            if (c[4] ^ field[t]) c = {c[3:0], 1'b0} ^ 5'b00101;
            else                 c = {c[3:0], 1'b0};
            v[15-t] = field[t];
        end
        v[4:0] = ~c;
        return v;
    endfunction

    // CRC5 engine stub: gap and mid-CRC ready drop are configurable.
    typedef enum {E_IDLE, E_SHIFT, E_WAIT, E_OUT, E_DONE} e_st_t;
    e_st_t      e_st;
    logic [4:0] e_crc, e_inv;
    logic [2:0] e_ci;
    int         e_n, e_w, e_dleft;
    int         gap_cfg = 7;
    logic       drop_en = 1'b0;
    int         drop_len = 2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_st <= E_IDLE; e_crc <= '0; e_n <= 0; e_w <= 0; e_ci <= '0; e_dleft <= 0;
            crc5_ready <= 1'b0; crc5_done <= 1'b0;
        end else begin
            case (e_st)
                E_IDLE: if (crc5_start) begin e_crc <= 5'h1F; e_n <= 0; e_st <= E_SHIFT; end
                E_SHIFT: begin
                    e_crc <= {e_crc[3:0], 1'b0} ^ ((e_crc[4] ^ crc5_sin) ? 5'b00101 : 5'b00000);
                    e_n <= e_n + 1;
                    if (e_n == 10) begin e_w <= 0; e_st <= E_WAIT; end
                end
                E_WAIT: if (e_w == gap_cfg - 1) begin
                    crc5_ready <= 1'b1; e_ci <= '0; e_st <= E_OUT;
                end else e_w <= e_w + 1;
                E_OUT: if (crc5_ready) begin
                    if (e_ci == 3'd4) begin
                        crc5_ready <= 1'b0; crc5_done <= 1'b1; e_st <= E_DONE;
                    end else begin
                        e_ci <= e_ci + 3'd1;
                        if (drop_en && e_ci == 3'd1) begin crc5_ready <= 1'b0; e_dleft <= drop_len; end
                    end
                end else begin
                    if (e_dleft == 1) crc5_ready <= 1'b1;
                    e_dleft <= e_dleft - 1;
                end
                E_DONE: if (crc5_rec) begin crc5_done <= 1'b0; e_st <= E_IDLE; end
                default: e_st <= E_IDLE;
            endcase
        end
    end

    assign e_inv    = ~e_crc;
    assign crc5_out = crc5_ready ? e_inv[3'd4 - e_ci] : 1'b0;

    // Compare process state
    logic        exp_q[$];
    int          idx = 0, gap_run = 0, holes = 0, starts = 0;
    int          pkt_count = 0, idle_run = 0, last_idle = -1;
    int          last_len = 0, last_gap = 0, last_holes = 0, last_starts = 0;
    logic        counting_idle = 1'b0;
    logic [31:0] obs = '0, last_pkt = '0;
    logic        exp_start, exp_sin, exp_eop, e_bit;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs", {25'd0, out_bit, out_valid, out_eop, crc5_start, crc5_sin, crc5_rec, tok_if.tok_busy}, 32'd0);
                idx = 0; gap_run = 0; holes = 0; starts = 0; counting_idle = 1'b0;
            end else begin
                exp_start = out_valid && idx == 15;
                exp_sin   = (out_valid && idx >= 16 && idx <= 26) ? out_bit : 1'b0;
                exp_eop   = (idx == 32) && crc5_done;
                chk("crc5_start", {31'd0, crc5_start}, {31'd0, exp_start});
                chk("crc5_sin",   {31'd0, crc5_sin},   {31'd0, exp_sin});
                chk("out_eop",    {31'd0, out_eop},    {31'd0, exp_eop});
                chk("crc5_rec",   {31'd0, crc5_rec},   {31'd0, exp_eop});
                if (out_valid || out_eop || idx != 0)
                    chk("tok_busy", {31'd0, tok_if.tok_busy}, 32'd1);
                if (crc5_start) starts++;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_bit: out_valid with no expected bit (t=%0t)", $time);
                    end else begin
                        e_bit = exp_q.pop_front();
                        chk("out_bit", {31'd0, out_bit}, {31'd0, e_bit});
                    end
                    if (idx < 32) obs[31-idx] = out_bit;
                    idx++;
                end else if (idx == 27) begin
                    gap_run++;
                end else if (idx > 27 && idx < 32) begin
                    holes++;
                end
                if (out_eop) begin
                    last_pkt = obs; last_len = idx; last_gap = gap_run;
                    last_holes = holes; last_starts = starts;
                    idx = 0; gap_run = 0; holes = 0; starts = 0; obs = '0;
                    pkt_count++;
                    counting_idle = 1'b1; idle_run = 0;
                end else if (counting_idle) begin
                    if (tok_if.tok_busy) begin last_idle = idle_run; counting_idle = 1'b0; end
                    else idle_run++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive_fields(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                                input logic sof, input logic [10:0] frame);
        tok_if.tok_pid  = pid;
        tok_if.tok_addr = addr;
        tok_if.tok_endp = endp;
`ifdef USB_SOF_EN
        tok_if.tok_sof   = sof;
        tok_if.tok_frame = frame;
`endif
    endtask

    task automatic push_pkt(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) exp_q.push_back(v[i]);
    endtask

    task automatic wait_pkts(input int target, input int budget);
        for (int i = 0; i < budget && pkt_count < target; i++) step();
        chk("pkt_timeout", {31'd0, pkt_count >= target}, 32'd1);
    endtask

    task automatic send(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                        input logic sof, input logic [10:0] frame);
        int c0;
        c0 = pkt_count;
        step();
        drive_fields(pid, addr, endp, sof, frame);
        tok_if.tok_req = 1'b1;
        push_pkt(sof ? build_pkt(PID_SOF, frame) : build_pkt(pid, {endp, addr}));
        step();
        tok_if.tok_req = 1'b0;
        wait_pkts(c0 + 1, 300);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m;
        int c0;
        int i;
        tok_if.tok_req = 1'b0;
        drive_fields(4'd0, 7'd0, 4'd0, 1'b0, 11'd0);

        // Model pins
        m = build_pkt(PID_SETUP, 11'd0);
        chk("model_setup_pkt", m, 32'h01B4_0008);
        m = build_pkt(PID_IN, {4'hE, 7'h15});
        chk("model_in_pid", {24'd0, m[23:16]}, {24'd0, 8'b1001_0110});

        #22 rst_n = 1'b1;
        repeat (2) step();
        chk("idle_busy", {31'd0, tok_if.tok_busy}, 32'd0);

        // SETUP addr 0 endp 0 with the 7-cycle engine
        send(PID_SETUP, 7'd0, 4'd0, 1'b0, 11'd0);
        chk("setup_wire", last_pkt, 32'h01B4_0008);
        chk("setup_gap", last_gap, 32'd7);
        chk("setup_len", last_len, 32'd32);

        // IN addr 15h endp Eh
        send(PID_IN, 7'h15, 4'hE, 1'b0, 11'd0);
        chk("in_start_pulses", last_starts, 32'd1);
        chk("in_pid_wire", {24'd0, last_pkt[23:16]}, {24'd0, 8'b1001_0110});
        chk("in_data_wire", {21'd0, last_pkt[15:5]}, {21'd0, 11'b10101_0001_11});

        // Slow engine: 20-cycle gap and a 2-cycle drop mid-CRC
        step();
        gap_cfg = 20; drop_en = 1'b1;
        send(PID_OUT, 7'h5A, 4'h3, 1'b0, 11'd0);
        chk("slow_gap", last_gap, 32'd20);
        chk("slow_holes", last_holes, 32'd2);
        chk("slow_len", last_len, 32'd32);
        gap_cfg = 7; drop_en = 1'b0;

        // Back-to-back with tok_req held; fields changed during busy are taken at the next accept
        c0 = pkt_count;
        step();
        drive_fields(PID_IN, 7'h03, 4'h1, 1'b0, 11'd0);
        tok_if.tok_req = 1'b1;
        push_pkt(build_pkt(PID_IN, {4'h1, 7'h03}));
        i = 0;
        do begin step(); i++; end while (!tok_if.tok_busy && i < 20);
        drive_fields(PID_OUT, 7'h40, 4'h2, 1'b0, 11'd0);
        push_pkt(build_pkt(PID_OUT, {4'h2, 7'h40}));
        wait_pkts(c0 + 1, 300);
        i = 0;
        do begin step(); i++; end while (!tok_if.tok_busy && i < 20);
        tok_if.tok_req = 1'b0;
        wait_pkts(c0 + 2, 300);
        chk("b2b_idle_gap", last_idle, 32'd1);

        // A request pulsed while busy is ignored
        c0 = pkt_count;
        step();
        drive_fields(PID_SETUP, 7'h11, 4'h4, 1'b0, 11'd0);
        tok_if.tok_req = 1'b1;
        push_pkt(build_pkt(PID_SETUP, {4'h4, 7'h11}));
        step();
        tok_if.tok_req = 1'b0;
        repeat (5) step();
        drive_fields(PID_IN, 7'h7F, 4'hF, 1'b0, 11'd0);
        tok_if.tok_req = 1'b1;
        step();
        tok_if.tok_req = 1'b0;
        wait_pkts(c0 + 1, 300);
        repeat (10) step();
        chk("ignored_req_pkts", pkt_count, c0 + 1);
        chk("ignored_req_busy", {31'd0, tok_if.tok_busy}, 32'd0);

        // Reset on DATA bit 5
        c0 = pkt_count;
        step();
        drive_fields(PID_OUT, 7'h2B, 4'h6, 1'b0, 11'd0);
        tok_if.tok_req = 1'b1;
        push_pkt(build_pkt(PID_OUT, {4'h6, 7'h2B}));
        step();
        tok_if.tok_req = 1'b0;
        i = 0;
        while (idx != 21 && i < 100) begin step(); i++; end
        chk("reach_data_bit5", idx, 32'd21);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_outputs", {25'd0, out_bit, out_valid, out_eop, crc5_start, crc5_sin, crc5_rec, tok_if.tok_busy}, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (2) step();
        chk("abort_no_eop", pkt_count, c0);
        send(PID_SETUP, 7'd0, 4'd0, 1'b0, 11'd0);
        chk("post_reset_wire", last_pkt, 32'h01B4_0008);
        chk("post_reset_len", last_len, 32'd32);

`ifdef USB_SOF_EN
        send(PID_OUT, 7'h7F, 4'hF, 1'b1, 11'h2A5);
        chk("sof_pid_wire", {24'd0, last_pkt[23:16]}, {24'd0, 8'b1010_0101});
        chk("sof_frame_wire", {21'd0, last_pkt[15:5]}, {21'd0, 11'b10100_1010_10});
`endif

        repeat (5) step();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/usb_token_tx.md
USB_TOKEN_TX -- requirements
Module: usb_token_tx

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have port tok_req, input, 1, start-token request; sampled only in IDLE.
REQ-004 SHALL have port tok_pid, input, 4, token PID (OUT/IN/SETUP); captured at accept.
REQ-005 SHALL have port tok_addr, input, 7, device address; captured at accept.
REQ-006 SHALL have port tok_endp, input, 4, endpoint number; captured at accept.
REQ-007 SHALL have port tok_busy, output, 1, high from accept until the EOP cycle inclusive.
REQ-008 SHALL have port out_bit, output, 1, serial wire bit, LSB-first per field.
REQ-009 SHALL have port out_valid, output, 1, out_bit is meaningful this cycle.
REQ-010 SHALL have port out_eop, output, 1, one-cycle end-of-packet strobe to the downstream stuffer/NRZI stage.
REQ-011 SHALL have port crc5_start, output, 1, one-cycle start pulse to the CRC5 engine.
REQ-012 SHALL have port crc5_sin, output, 1, serial data bit to the CRC5 engine (its s_in).
REQ-013 SHALL have port crc5_rec, output, 1, one-cycle acknowledgement that the CRC has been consumed.
REQ-014 SHALL have port crc5_out, input, 1, CRC bit from the engine.
REQ-015 SHALL have port crc5_ready, input, 1, crc5_out is valid this cycle.
REQ-016 SHALL have port crc5_done, input, 1, the engine is holding in its done state.

Function
REQ-017 SHALL implement states IDLE, SYNC, PID, DATA, WAIT_CRC, CRC, EOP, using a 4-bit bit counter.
REQ-018 IDLE, with tok_req=1, SHALL capture pid/addr/endp, assert tok_busy and enter SYNC next cycle; when tok_busy=1, tok_req is ignored.
REQ-019 SYNC SHALL emit 8 bits of constant SYNC_BYTE=8'h80 LSB-first (seven 0s then a 1), with out_valid=1.
REQ-020 PID SHALL emit 8 bits {~pid,pid} LSB-first, with out_valid=1.
REQ-021 crc5_start SHALL be high exactly in the cycle carrying the 8th PID bit.
REQ-022 DATA SHALL emit 11 bits (addr[0..6], then endp[0..3]) with out_valid=1.
REQ-023 In DATA, crc5_sin SHALL equal out_bit in the same cycle.
REQ-024 crc5_sin SHALL be 0 outside DATA.
REQ-025 WAIT_CRC SHALL drive out_valid=0 and hold until crc5_ready=1; the gap length is set by the engine (7 cycles with the team CRC5 engine) and SHALL NOT be hard-coded.
REQ-026 CRC SHALL drive out_bit=crc5_out and out_valid=crc5_ready, count 5 valid bits, then enter EOP.
REQ-027 EOP SHALL wait for crc5_done=1, then in that cycle pulse crc5_rec and out_eop together, then return to IDLE with tok_busy=0.
REQ-028 If crc5_ready drops before 5 CRC bits are counted, the block SHALL keep waiting with out_valid=0; only counted bits are emitted.
REQ-029 A tok_req held high across the EOP cycle SHALL be accepted in the first IDLE cycle, giving one idle cycle between packets.

Reset
REQ-030 While rst_n=0, the state SHALL be IDLE and the counter and capture registers SHALL be 0.
REQ-031 While rst_n=0, every output SHALL be 0.
REQ-032 Reset asserted mid-packet SHALL abort immediately without out_eop or crc5_rec; the CRC5 engine shares rst_n.

Configuration
REQ-033 With USB_SOF_EN defined, the block SHALL add inputs tok_sof (1) and tok_frame (11).
REQ-034 With USB_SOF_EN defined and tok_sof=1 at accept, the PID SHALL be forced to SOF (4'b0101) and DATA SHALL emit frame[0..10], ignoring pid/addr/endp.
REQ-035 Without USB_SOF_EN, those ports SHALL be absent and only addr/endp tokens are sent.

Structure
REQ-036 Shared package usb_pkg SHALL hold the PID enum (OUT 4'b0001, IN 4'b1001, SETUP 4'b1101, SOF 4'b0101), SYNC_BYTE and the state enum.
REQ-037 One sub-module, the existing piso_register (width 11), SHALL be used for field serialisation; the bit counter and FSM SHALL live in usb_token_tx.

Verification
REQ-038 SETUP, addr 0, endp 0, with the team CRC5 engine -> wire 0000_0001, 1011_0100, eleven 0s, 7-cycle gap, CRC field 5'b01000 on the wire (5'b00010 USB CRC), then out_eop.
REQ-039 IN, addr 7'h15, endp 4'hE -> crc5_start only on PID bit 8, and crc5_sin equals out_bit for all 11 DATA cycles.
REQ-040 Stub engine delaying crc5_ready by 20 cycles and dropping it for 2 cycles mid-CRC -> out_valid stays low in both gaps and exactly 5 CRC bits are emitted.
REQ-041 tok_req held high continuously -> back-to-back packets with exactly 1 IDLE cycle, and a second request during busy is ignored.
REQ-042 rst_n asserted on DATA bit 5 -> all outputs 0 immediately, no out_eop, and the next request produces a full correct packet.
REQ-043 USB_SOF_EN with tok_sof=1, frame 11'h2A5 -> PID byte 8'hA5 and frame bits LSB-first.
